// File: rtl/bnn_dot_accumulator.sv
// Binary (XNOR/popcount) dot-product accumulator: two-stage pipeline turning LANES-wide
// +/-1 chunks into a saturated full-length sum, a thresholded activation bit and an overflow flag.
module bnn_dot_accumulator #(
  parameter int LANES  = 9,
  parameter int ACC_W  = 16,
  parameter int SKIP_W = $clog2(LANES + 1)
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    last_in,
  input  logic [LANES-1:0]        activation_in,
  input  logic [LANES-1:0]        weight_in,
  input  logic [SKIP_W-1:0]       skip_in,
  input  logic signed [ACC_W-1:0] threshold_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic signed [ACC_W-1:0] psum_out,
  output logic                    bit_out,
  output logic                    overflow_out
);

  localparam int CHUNK_W = $clog2(LANES) + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_last_q, s1_last_d;
  logic signed [CHUNK_W-1:0] s1_sum_q, s1_sum_d;
  logic signed [ACC_W-1:0]   s1_thr_q, s1_thr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      sticky_q, sticky_d;
  logic                      valid_q, valid_d;
  logic signed [ACC_W-1:0]   psum_q, psum_d;
  logic                      bit_q, bit_d;
  logic                      ovf_q, ovf_d;

  logic                      stall_s;
  logic                      accept_s;
  logic [SKIP_W-1:0]         eff_skip_s;
  logic [SKIP_W-1:0]         active_lim_s;
  logic [CHUNK_W-1:0]        pop_s;
  logic                      lane_hit_s;
  logic signed [CHUNK_W-1:0] chunk_sum_s;
  logic signed [ACC_W-1:0]   base_s;
  logic [ACC_W:0]            wide_s;
  logic                      sat_s;
  logic                      sticky_base_s;
  logic                      sticky_new_s;
  logic signed [ACC_W-1:0]   new_s;

  assign stall_s   = valid_q & ~ready_in;
  assign ready_out = ~stall_s & ~reset_in;
  assign accept_s  = valid_in & ready_out;

  assign valid_out    = valid_q;
  assign psum_out     = psum_q;
  assign bit_out      = bit_q;
  assign overflow_out = ovf_q;

  // Chunk sum: skipped lanes are excluded from both the match count and the active count.
  always_comb begin
    pop_s      = '0;
    lane_hit_s = 1'b0;
    if (skip_in > SKIP_W'(LANES)) begin
      eff_skip_s = SKIP_W'(LANES);
    end else begin
      eff_skip_s = skip_in;
    end
    active_lim_s = SKIP_W'(LANES) - eff_skip_s;
    for (int i = 0; i < LANES; i++) begin
      lane_hit_s = (SKIP_W'(i) < active_lim_s) & (activation_in[i] ~^ weight_in[i]);
      pop_s      = pop_s + {{(CHUNK_W-1){1'b0}}, lane_hit_s};
    end
    chunk_sum_s = $signed((pop_s << 1) - {{(CHUNK_W-SKIP_W){1'b0}}, active_lim_s});
  end

  // Stage-2 datapath and next-state logic; everything holds while the result is stalled.
  always_comb begin
    state_d    = state_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_sum_d   = s1_sum_q;
    s1_thr_d   = s1_thr_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    valid_d    = valid_q;
    psum_d     = psum_q;
    bit_d      = bit_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        base_s        = '0;
        sticky_base_s = 1'b0;
      end
      ACCUM: begin
        base_s        = acc_q;
        sticky_base_s = sticky_q;
      end
      default: begin
        base_s        = '0;
        sticky_base_s = 1'b0;
      end
    endcase

    // One guard bit detects two's-complement overflow of base + chunk.
    wide_s       = {base_s[ACC_W-1], base_s} +
                   {{(ACC_W+1-CHUNK_W){s1_sum_q[CHUNK_W-1]}}, s1_sum_q};
    sat_s        = wide_s[ACC_W] ^ wide_s[ACC_W-1];
    sticky_new_s = sticky_base_s | sat_s;
    if (!sat_s) begin
      new_s = $signed(wide_s[ACC_W-1:0]);
    end else if (wide_s[ACC_W]) begin
      new_s = ACC_MIN;
    end else begin
      new_s = ACC_MAX;
    end

    if (!stall_s) begin
      s1_valid_d = accept_s;
      valid_d    = 1'b0;
      if (accept_s) begin
        s1_last_d = last_in;
        s1_sum_d  = chunk_sum_s;
        if (last_in) begin
          s1_thr_d = threshold_in;
        end else begin
          s1_thr_d = s1_thr_q;
        end
      end else begin
        s1_last_d = s1_last_q;
      end
      if (s1_valid_q && s1_last_q) begin
        psum_d   = new_s;
        bit_d    = (new_s >= s1_thr_q);
        ovf_d    = sticky_new_s;
        valid_d  = 1'b1;
        acc_d    = '0;
        sticky_d = 1'b0;
        state_d  = IDLE;
      end else if (s1_valid_q) begin
        acc_d    = new_s;
        sticky_d = sticky_new_s;
        state_d  = ACCUM;
      end else begin
        state_d  = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      s1_thr_q   <= '0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
      valid_q    <= 1'b0;
      psum_q     <= '0;
      bit_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_sum_q   <= s1_sum_d;
      s1_thr_q   <= s1_thr_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
      valid_q    <= valid_d;
      psum_q     <= psum_d;
      bit_q      <= bit_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bnn_dot_accumulator.sv
// Directed bench: default instance (ACC_W=16) and a narrow instance (ACC_W=6) share
// all inputs; expected results are hand-computed chunk sums.
module tb_bnn_dot_accumulator;

  logic              clk;
  logic              reset_in;
  logic              valid_in;
  logic              last_in;
  logic [8:0]        act;
  logic [8:0]        wgt;
  logic [3:0]        skip;
  logic signed [15:0] thr0;
  logic              ready_in;

  logic              rdy0, rdy1;
  logic              valid0, valid1;
  logic signed [15:0] psum0;
  logic signed [5:0] psum1;
  logic              bit0, bit1;
  logic              ovf0, ovf1;

  int n_checks = 0;
  int n_errors = 0;

  bnn_dot_accumulator #(.LANES(9), .ACC_W(16)) u0 (
    .clk_in(clk), .reset_in(reset_in), .valid_in(valid_in), .ready_out(rdy0),
    .last_in(last_in), .activation_in(act), .weight_in(wgt), .skip_in(skip),
    .threshold_in(thr0), .valid_out(valid0), .ready_in(ready_in),
    .psum_out(psum0), .bit_out(bit0), .overflow_out(ovf0)
  );

  bnn_dot_accumulator #(.LANES(9), .ACC_W(6)) u1 (
    .clk_in(clk), .reset_in(reset_in), .valid_in(valid_in), .ready_out(rdy1),
    .last_in(last_in), .activation_in(act), .weight_in(wgt), .skip_in(skip),
    .threshold_in(thr0[5:0]), .valid_out(valid1), .ready_in(ready_in),
    .psum_out(psum1), .bit_out(bit1), .overflow_out(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one chunk and return just after the edge that accepts it; valid_in stays high.
  task automatic send(input logic [8:0] a, input logic [8:0] w, input logic [3:0] sk,
                      input logic l, input int t);
    int n;
    act      = a;
    wgt      = w;
    skip     = sk;
    last_in  = l;
    thr0     = 16'(t);
    valid_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("send_ready", int'(rdy0), 1);
    step();
  endtask

  task automatic expect_res(input string tag, input int p0, input int b0, input int o0,
                            input int p1, input int b1, input int o1);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_valid0"}, int'(valid0), 1);
    check_val({tag, "_psum0"},  int'(psum0), p0);
    check_val({tag, "_bit0"},   int'(bit0), b0);
    check_val({tag, "_ovf0"},   int'(ovf0), o0);
    check_val({tag, "_valid1"}, int'(valid1), 1);
    check_val({tag, "_psum1"},  int'(psum1), p1);
    check_val({tag, "_bit1"},   int'(bit1), b1);
    check_val({tag, "_ovf1"},   int'(ovf1), o1);
    step();
  endtask

  initial begin
    reset_in = 1'b1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    act      = '0;
    wgt      = '0;
    skip     = '0;
    thr0     = '0;
    ready_in = 1'b1;

    @(negedge clk);
    check_val("rst_valid", int'(valid0), 0);
    check_val("rst_psum",  int'(psum0), 0);
    check_val("rst_bit",   int'(bit0), 0);
    check_val("rst_ovf",   int'(ovf0), 0);
    check_val("rst_ready", int'(rdy0), 0);
    step();
    reset_in = 1'b0;
    step();

    // Single chunk, all lanes match: +9; exact two-edge latency.
    send(9'h1FF, 9'h1FF, 4'd0, 1'b1, 0);
    valid_in = 1'b0;
    @(negedge clk);
    check_val("single_lat", int'(valid0), 0);
    expect_res("single", 9, 1, 0, 9, 1, 0);

    // Skip 3 of 9 lanes, all mismatching -> -6; oversize skip -> 0 (0 >= 0).
    send(9'h000, 9'h1FF, 4'd3, 1'b1, 0);
    valid_in = 1'b0;
    expect_res("skip3", -6, 0, 0, -6, 0, 0);
    send(9'h000, 9'h1FF, 4'd15, 1'b1, 0);
    valid_in = 1'b0;
    expect_res("skip15", 0, 1, 0, 0, 1, 0);

    // Back-to-back: (+9, -9, +5 last thr 6) then (+3 last thr 3).
    send(9'h1FF, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h000, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h1FF, 9'h07F, 4'd0, 1'b1, 6);
    send(9'h1FF, 9'h03F, 4'd0, 1'b1, 3);
    valid_in = 1'b0;
    @(negedge clk);
    check_val("b2b_v1", int'(valid0), 1);
    check_val("b2b_p1", int'(psum0), 5);
    check_val("b2b_b1", int'(bit0), 0);
    @(negedge clk);
    check_val("b2b_v2", int'(valid0), 1);
    check_val("b2b_p2", int'(psum0), 3);
    check_val("b2b_b2", int'(bit0), 1);
    @(negedge clk);
    check_val("b2b_v3", int'(valid0), 0);
    step();

    // Backpressure: result 5 stalls, +3 sits in stage 1, next chunk (+1 last thr 0) waits.
    ready_in = 1'b0;
    send(9'h1FF, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h000, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h1FF, 9'h07F, 4'd0, 1'b1, 6);
    send(9'h1FF, 9'h03F, 4'd0, 1'b1, 3);
    act     = 9'h1FF;
    wgt     = 9'h01F;
    skip    = 4'd0;
    last_in = 1'b1;
    thr0    = 16'sd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_hold_valid", int'(valid0), 1);
      check_val("bp_hold_psum",  int'(psum0), 5);
      check_val("bp_hold_rdy",   int'(rdy0), 0);
    end
    step();
    ready_in = 1'b1;
    @(negedge clk);
    check_val("bp_rel_rdy",  int'(rdy0), 1);
    check_val("bp_rel_psum", int'(psum0), 5);
    step();
    valid_in = 1'b0;
    @(negedge clk);
    check_val("bp_r2_valid", int'(valid0), 1);
    check_val("bp_r2_psum",  int'(psum0), 3);
    check_val("bp_r2_bit",   int'(bit0), 1);
    @(negedge clk);
    check_val("bp_r3_valid", int'(valid0), 1);
    check_val("bp_r3_psum",  int'(psum0), 1);
    check_val("bp_r3_bit",   int'(bit0), 1);
    @(negedge clk);
    check_val("bp_idle", int'(valid0), 0);
    step();

    // Saturation: 4 x +9 = 36 -> narrow instance clamps to 31 with overflow; then -9 clean.
    send(9'h1FF, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h1FF, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h1FF, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h1FF, 9'h1FF, 4'd0, 1'b1, 0);
    valid_in = 1'b0;
    expect_res("sat", 36, 1, 0, 31, 1, 1);
    send(9'h000, 9'h1FF, 4'd0, 1'b1, 0);
    valid_in = 1'b0;
    expect_res("post_sat", -9, 0, 0, -9, 0, 0);

    // Reset mid dot-product discards the partial sum.
    send(9'h1FF, 9'h1FF, 4'd0, 1'b0, 0);
    send(9'h1FF, 9'h1FF, 4'd0, 1'b0, 0);
    valid_in = 1'b0;
    reset_in = 1'b1;
    @(negedge clk);
    check_val("mid_rst_valid", int'(valid0), 0);
    check_val("mid_rst_rdy0",  int'(rdy0), 0);
    check_val("mid_rst_rdy1",  int'(rdy1), 0);
    step();
    reset_in = 1'b0;
    send(9'h1FF, 9'h01F, 4'd0, 1'b1, 0);
    valid_in = 1'b0;
    expect_res("after_rst", 1, 1, 0, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
